// File: rtl/reaction_timer_fsm_if.sv
// Reaction timer bundle: sequencer/key inputs and result outputs.
// Optional best-time signals exist only when BEST_TIME_EN is defined.
interface reaction_timer_fsm_if #(
    parameter int CNT_W = 14
);
    logic             arm;
    logic             lights_out;
    logic             tick_ms;
    logic             press;
    logic [CNT_W-1:0] rt_ms;
    logic             result_valid;
    logic             jump_start;
    logic             timed_out;
    logic             busy;
`ifdef BEST_TIME_EN
    logic [CNT_W-1:0] best_ms;
    logic             new_best;

    modport master (
        output arm, lights_out, tick_ms, press,
        input  rt_ms, result_valid, jump_start, timed_out, busy,
        input  best_ms, new_best
    );

    modport slave (
        input  arm, lights_out, tick_ms, press,
        output rt_ms, result_valid, jump_start, timed_out, busy,
        output best_ms, new_best
    );
`else
    modport master (
        output arm, lights_out, tick_ms, press,
        input  rt_ms, result_valid, jump_start, timed_out, busy
    );

    modport slave (
        input  arm, lights_out, tick_ms, press,
        output rt_ms, result_valid, jump_start, timed_out, busy
    );
`endif
endinterface

// File: rtl/reaction_timer_fsm.sv
// Measures ms from lights-out to key press, flags jump starts and timeouts.
// Optional best-time tracking is enabled by defining BEST_TIME_EN.
module reaction_timer_fsm #(
    parameter int CNT_W        = 14,
    parameter int MAX_MS       = 9999,
    parameter int MIN_VALID_MS = 100
) (
    input  logic clk,
    input  logic rst_n,
    reaction_timer_fsm_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_TIMING = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MS);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_VALID_MS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] rt_q,    rt_d;
    logic             valid_q, valid_d;
    logic             jump_q,  jump_d;
    logic             tout_q,  tout_d;
    logic             busy_q,  busy_d;
    logic             press_q;

    logic             press_rise;
    logic [CNT_W-1:0] tick_val;

`ifdef BEST_TIME_EN
    logic [CNT_W-1:0] best_q,  best_d;
    logic             nbest_q, nbest_d;
`endif

    assign press_rise = bus.press & ~press_q;

    // Counter value including a tick in this cycle, saturated
    assign tick_val = (cnt_q == MAX_C) ? cnt_q
                    : cnt_q + {{(CNT_W-1){1'b0}}, bus.tick_ms};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rt_d    = rt_q;
        valid_d = valid_q;
        jump_d  = jump_q;
        tout_d  = tout_q;
`ifdef BEST_TIME_EN
        best_d  = best_q;
        nbest_d = 1'b0;
`endif
        if (bus.arm) begin
            state_d = S_ARMED;
            cnt_d   = '0;
            valid_d = 1'b0;
            jump_d  = 1'b0;
            tout_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_ARMED: begin
                    if (press_rise) begin
                        state_d = S_DONE;
                        rt_d    = '0;
                        jump_d  = 1'b1;
                        valid_d = 1'b1;
                    end else if (bus.lights_out) begin
                        state_d = S_TIMING;
                        cnt_d   = '0;
                    end
                end
                S_TIMING: begin
                    cnt_d = tick_val;
                    if (press_rise) begin
                        state_d = S_DONE;
                        rt_d    = tick_val;
                        jump_d  = (tick_val < MIN_C);
                        valid_d = 1'b1;
`ifdef BEST_TIME_EN
                        if (!(tick_val < MIN_C) && (tick_val < best_q)) begin
                            best_d  = tick_val;
                            nbest_d = 1'b1;
                        end
`endif
                    end else if (tick_val == MAX_C) begin
                        state_d = S_DONE;
                        rt_d    = MAX_C;
                        tout_d  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy_d = (state_d == S_ARMED) | (state_d == S_TIMING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rt_q    <= '0;
            valid_q <= 1'b0;
            jump_q  <= 1'b0;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rt_q    <= rt_d;
            valid_q <= valid_d;
            jump_q  <= jump_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
            press_q <= bus.press;
        end
    end

`ifdef BEST_TIME_EN
    // Best time survives arm; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q  <= MAX_C;
            nbest_q <= 1'b0;
        end else begin
            best_q  <= best_d;
            nbest_q <= nbest_d;
        end
    end

    assign bus.best_ms  = best_q;
    assign bus.new_best = nbest_q;
`endif

    assign bus.rt_ms        = rt_q;
    assign bus.result_valid = valid_q;
    assign bus.jump_start   = jump_q;
    assign bus.timed_out    = tout_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Directed bench for reaction_timer_fsm with a result scoreboard.
// Build with BEST_TIME_EN defined to also cover best-time tracking.
module tb_reaction_timer_fsm;

    localparam int CNT_W = 14;
    localparam int MAXV  = 9999;
    localparam int MINV  = 100;

    logic clk;
    logic rst_n;

    reaction_timer_fsm_if #(.CNT_W(CNT_W)) bus ();

    reaction_timer_fsm #(
        .CNT_W(CNT_W), .MAX_MS(MAXV), .MIN_VALID_MS(MINV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rt;
        logic        js;
        logic        to;
        logic        nb;
        logic [31:0] best;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_best = MAXV;
    int   nb_cnt = 0;

`ifdef BEST_TIME_EN
    always @(negedge clk) if (bus.new_best === 1'b1) nb_cnt++;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int rt, input bit to);
        exp_t e;
        e.rt = rt;
        e.to = to;
        e.js = !to && (rt < MINV);
        e.nb = !e.js && !to && (rt < model_best);
        if (e.nb) model_best = rt;
        e.best = model_best;
        sb.push_back(e);
    endtask

    task automatic pulse_arm();
        @(negedge clk) bus.arm = 1'b1;
        @(negedge clk) bus.arm = 1'b0;
    endtask

    task automatic pulse_go();
        @(negedge clk) bus.lights_out = 1'b1;
        @(negedge clk) bus.lights_out = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.tick_ms = 1'b1;
        end
        @(negedge clk) bus.tick_ms = 1'b0;
    endtask

    task automatic press_edge();
        @(negedge clk) bus.press = 1'b1;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int   k = 0;
        while (bus.result_valid !== 1'b1 && k < 12000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, bus.result_valid, 1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rt"},   bus.rt_ms,      e.rt);
            chk({tag, "_js"},   bus.jump_start, e.js);
            chk({tag, "_to"},   bus.timed_out,  e.to);
            chk({tag, "_busy"}, bus.busy,       0);
`ifdef BEST_TIME_EN
            chk({tag, "_nb"},   bus.new_best,   e.nb);
            chk({tag, "_best"}, bus.best_ms,    e.best);
`endif
        end
    endtask

    task automatic trial(input int n, input string tag);
        pulse_arm();
        pulse_go();
        ticks(n);
        push(n, 1'b0);
        press_edge();
        wait_result(tag);
        @(negedge clk) bus.press = 1'b0;
    endtask

    initial begin
        bus.arm        = 1'b0;
        bus.lights_out = 1'b0;
        bus.tick_ms    = 1'b0;
        bus.press      = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_rt",    bus.rt_ms,        0);
        chk("rst_busy",  bus.busy,         0);
`ifdef BEST_TIME_EN
        chk("rst_best",  bus.best_ms,      MAXV);
`endif
        rst_n = 1'b1;

        // idle ignores go/press
        pulse_go();
        press_edge();
        @(negedge clk) bus.press = 1'b0;
        @(negedge clk);
        chk("idle_valid", bus.result_valid, 0);
        chk("idle_busy",  bus.busy,         0);

        trial(237, "t1");

        // press before lights-out
        pulse_arm();
        chk("t2_arm_busy",  bus.busy,         1);
        chk("t2_arm_valid", bus.result_valid, 0);
        push(0, 1'b0);
        press_edge();
        wait_result("t2");
        @(negedge clk) bus.press = 1'b0;
        pulse_go();
        ticks(5);
        chk("t2_hold_rt", bus.rt_ms,      0);
        chk("t2_hold_js", bus.jump_start, 1);
        chk("t2_hold_v",  bus.result_valid, 1);

        trial(42, "t3a");

        // press in the same cycle as the 100th tick
        pulse_arm();
        pulse_go();
        ticks(99);
        push(100, 1'b0);
        @(negedge clk) begin
            bus.tick_ms = 1'b1;
            bus.press   = 1'b1;
        end
        @(negedge clk) bus.tick_ms = 1'b0;
        wait_result("t3b");
        @(negedge clk) bus.press = 1'b0;

        // timeout
        pulse_arm();
        pulse_go();
        push(MAXV, 1'b1);
        ticks(MAXV);
        wait_result("t4");
        press_edge();
        @(negedge clk) bus.press = 1'b0;
        @(negedge clk);
        chk("t4_late_rt", bus.rt_ms,     MAXV);
        chk("t4_late_to", bus.timed_out, 1);
        chk("t4_late_js", bus.jump_start, 0);

        // key held across arm and lights-out
        press_edge();
        pulse_arm();
        pulse_go();
        ticks(150);
        chk("t5_held_v",    bus.result_valid, 0);
        chk("t5_held_busy", bus.busy,         1);
        @(negedge clk) bus.press = 1'b0;
        ticks(150);
        push(300, 1'b0);
        press_edge();
        wait_result("t5");
        @(negedge clk) bus.press = 1'b0;

        // reset mid-measurement
        pulse_arm();
        pulse_go();
        ticks(50);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("t6_valid", bus.result_valid, 0);
        chk("t6_rt",    bus.rt_ms,        0);
        chk("t6_busy",  bus.busy,         0);
        chk("t6_js",    bus.jump_start,   0);
        chk("t6_to",    bus.timed_out,    0);
        model_best = MAXV;
`ifdef BEST_TIME_EN
        chk("t6_best",  bus.best_ms,      MAXV);
        chk("t6_nb",    bus.new_best,     0);
`endif
        @(negedge clk) rst_n = 1'b1;
        nb_cnt = 0;
        ticks(3);
        chk("t6_idle_busy", bus.busy, 0);

        trial(300, "b1");
        trial(250, "b2");
        trial(250, "b3");
        trial(400, "b4");
`ifdef BEST_TIME_EN
        chk("best_pulses", nb_cnt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
